// File: rtl/ls_unit.sv
// Load/store execution unit: takes one issued memory op, drives a held request to
// mem_ctrl, formats the returned data and broadcasts completion on the wb bus.
module ls_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned VLEN        = 128,
   parameter int unsigned SB_SIZE_WID = 4,
   parameter int unsigned REG_WID     = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sb_valid,
   output logic                   sb_vacant,
   input  logic                   sb_we,
   input  logic                   sb_vec,
   input  logic [2:0]             sb_funct,
   input  logic [XLEN-1:0]        sb_base,
   input  logic [XLEN-1:0]        sb_imm,
   input  logic [XLEN-1:0]        sb_len,
   input  logic [VLEN-1:0]        sb_src,
   input  logic [SB_SIZE_WID-1:0] sb_pos,
   input  logic [REG_WID-1:0]     sb_rd,
   output logic                   mc_valid,
   output logic                   mc_we,
   output logic [XLEN-1:0]        mc_addr,
   output logic [XLEN-1:0]        mc_len,
   output logic [VLEN-1:0]        mc_src,
   input  logic                   mc_done,
   input  logic [VLEN-1:0]        mc_data,
   output logic                   wb_valid,
   output logic [SB_SIZE_WID-1:0] wb_pos,
   output logic [REG_WID-1:0]     wb_rd,
   output logic [VLEN-1:0]        wb_value
);

   localparam int unsigned     NumBytes = VLEN / 8;
   localparam logic [XLEN-1:0] MaxLen   = XLEN'(NumBytes);

   typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

   state_e                 state_q, state_d;
   logic                   vacant_q, vacant_d;
   logic                   we_q, we_d;
   logic                   vec_q, vec_d;
   logic [2:0]             funct_q, funct_d;
   logic [XLEN-1:0]        addr_q, addr_d;
   logic [XLEN-1:0]        len_q, len_d;
   logic [VLEN-1:0]        src_q, src_d;
   logic [SB_SIZE_WID-1:0] pos_q, pos_d;
   logic [REG_WID-1:0]     rd_q, rd_d;
   logic [VLEN-1:0]        value_q, value_d;
   logic [XLEN-1:0]        issue_len;

   // Keep bytes [0, n) of d, zero the rest.
   function automatic logic [VLEN-1:0] mask_bytes(input logic [VLEN-1:0] d,
                                                  input logic [XLEN-1:0] n);
      logic [VLEN-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NumBytes; i++) begin
         if (XLEN'(i) < n) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   // Illegal encodings fall through to the word case.
   function automatic logic [VLEN-1:0] fmt_scalar(input logic [2:0] f,
                                                  input logic [XLEN-1:0] w);
      logic [XLEN-1:0] r;
      case (f)
         3'b000:  r = {{(XLEN-8){w[7]}}, w[7:0]};
         3'b001:  r = {{(XLEN-16){w[15]}}, w[15:0]};
         3'b100:  r = {{(XLEN-8){1'b0}}, w[7:0]};
         3'b101:  r = {{(XLEN-16){1'b0}}, w[15:0]};
         default: r = w;
      endcase
      return VLEN'(r);
   endfunction

   always_comb begin
      issue_len = XLEN'(4);
      if (sb_vec) begin
         issue_len = (sb_len > MaxLen) ? MaxLen : sb_len;
      end else begin
         case (sb_funct[1:0])
            2'b00:   issue_len = XLEN'(1);
            2'b01:   issue_len = XLEN'(2);
            default: issue_len = XLEN'(4);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         vacant_q <= 1'b1;
         we_q     <= 1'b0;
         vec_q    <= 1'b0;
         funct_q  <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         src_q    <= '0;
         pos_q    <= '0;
         rd_q     <= '0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         vacant_q <= vacant_d;
         we_q     <= we_d;
         vec_q    <= vec_d;
         funct_q  <= funct_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         src_q    <= src_d;
         pos_q    <= pos_d;
         rd_q     <= rd_d;
         value_q  <= value_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      vec_d   = vec_q;
      funct_d = funct_q;
      addr_d  = addr_q;
      len_d   = len_q;
      src_d   = src_q;
      pos_d   = pos_q;
      rd_d    = rd_q;
      value_d = value_q;
      unique case (state_q)
         StIdle: begin
            if (sb_valid) begin
               we_d    = sb_we;
               vec_d   = sb_vec;
               funct_d = sb_funct;
               addr_d  = sb_base + sb_imm;
               len_d   = issue_len;
               src_d   = mask_bytes(sb_src, issue_len);
               pos_d   = sb_pos;
               rd_d    = sb_rd;
               value_d = '0;
               state_d = (issue_len == '0) ? StWb : StReq;
            end
         end
         StReq: begin
            if (mc_done) begin
               value_d = vec_q ? mask_bytes(mc_data, len_q)
                               : fmt_scalar(funct_q, mc_data[XLEN-1:0]);
               state_d = StWb;
            end
         end
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
      vacant_d = (state_d == StIdle);
   end

   always_comb begin
      sb_vacant = vacant_q;
      mc_valid  = (state_q == StReq);
      mc_we     = we_q;
      mc_addr   = addr_q;
      mc_len    = len_q;
      mc_src    = src_q;
      wb_valid  = (state_q == StWb);
      wb_pos    = wb_valid ? pos_q : '0;
      wb_rd     = (wb_valid && !we_q) ? rd_q : '0;
      wb_value  = (wb_valid && !we_q) ? value_q : '0;
   end

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: inputs driven and outputs sampled on the falling edge.
module tb_ls_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         sb_valid, sb_vacant, sb_we, sb_vec;
   logic [2:0]   sb_funct;
   logic [31:0]  sb_base, sb_imm, sb_len;
   logic [127:0] sb_src;
   logic [3:0]   sb_pos;
   logic [4:0]   sb_rd;
   logic         mc_valid, mc_we, mc_done;
   logic [31:0]  mc_addr, mc_len;
   logic [127:0] mc_src, mc_data;
   logic         wb_valid;
   logic [3:0]   wb_pos;
   logic [4:0]   wb_rd;
   logic [127:0] wb_value;

   int checks = 0;
   int errors = 0;
   logic seen_wb;

   ls_unit dut (
      .clk(clk), .rst(rst),
      .sb_valid(sb_valid), .sb_vacant(sb_vacant), .sb_we(sb_we), .sb_vec(sb_vec),
      .sb_funct(sb_funct), .sb_base(sb_base), .sb_imm(sb_imm), .sb_len(sb_len),
      .sb_src(sb_src), .sb_pos(sb_pos), .sb_rd(sb_rd),
      .mc_valid(mc_valid), .mc_we(mc_we), .mc_addr(mc_addr), .mc_len(mc_len),
      .mc_src(mc_src), .mc_done(mc_done), .mc_data(mc_data),
      .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_rd(wb_rd), .wb_value(wb_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_op(input logic we, input logic vec, input logic [2:0] funct,
                         input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] len, input logic [127:0] src,
                         input logic [3:0] pos, input logic [4:0] rd);
      sb_we = we; sb_vec = vec; sb_funct = funct; sb_base = base; sb_imm = imm;
      sb_len = len; sb_src = src; sb_pos = pos; sb_rd = rd;
   endtask

   // Present one op for one cycle; returns at the falling edge after acceptance.
   task automatic issue(input logic we, input logic vec, input logic [2:0] funct,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] len, input logic [127:0] src,
                        input logic [3:0] pos, input logic [4:0] rd);
      set_op(we, vec, funct, base, imm, len, src, pos, rd);
      sb_valid = 1'b1;
      @(negedge clk);
      sb_valid = 1'b0;
   endtask

   // Wait, pulse mc_done with data; returns at the falling edge of the WB cycle.
   task automatic complete(input int wait_cycles, input logic [127:0] data);
      repeat (wait_cycles) @(negedge clk);
      mc_done = 1'b1;
      mc_data = data;
      @(negedge clk);
      mc_done = 1'b0;
      mc_data = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; sb_valid = 1'b0; mc_done = 1'b0; mc_data = '0;
      set_op(1'b0, 1'b0, 3'b000, '0, '0, '0, '0, '0, '0);
      repeat (3) @(negedge clk);
      check("rst_vacant", 128'(sb_vacant), 128'd1);
      check("rst_mc_valid", 128'(mc_valid), 128'd0);
      check("rst_wb_valid", 128'(wb_valid), 128'd0);
      check("rst_wb_value", wb_value, 128'd0);
      rst = 1'b1;
      @(negedge clk);

      // LB with negative offset, 5-cycle memory wait
      issue(1'b0, 1'b0, 3'b000, 32'h100, 32'hFFFF_FFFC, 32'd0, '0, 4'd3, 5'd7);
      check("lb_mc_valid", 128'(mc_valid), 128'd1);
      check("lb_addr", 128'(mc_addr), 128'hFC);
      check("lb_len", 128'(mc_len), 128'd1);
      check("lb_we", 128'(mc_we), 128'd0);
      check("lb_vacant", 128'(sb_vacant), 128'd0);
      complete(4, 128'h1234_5678_9ABC_DEF0_1111_2222_3333_4480);
      check("lb_wb_valid", 128'(wb_valid), 128'd1);
      check("lb_wb_mc_valid", 128'(mc_valid), 128'd0);
      check("lb_value", wb_value, 128'hFFFF_FF80);
      check("lb_rd", 128'(wb_rd), 128'd7);
      check("lb_pos", 128'(wb_pos), 128'd3);
      @(negedge clk);
      check("lb_wb_once", 128'(wb_valid), 128'd0);
      check("lb_vacant_back", 128'(sb_vacant), 128'd1);

      // LHU with garbage above the half-word
      issue(1'b0, 1'b0, 3'b101, 32'h200, 32'd4, 32'd0, '0, 4'd5, 5'd9);
      check("lhu_len", 128'(mc_len), 128'd2);
      check("lhu_addr", 128'(mc_addr), 128'h204);
      complete(1, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_BEEF);
      check("lhu_value", wb_value, 128'h0000_BEEF);
      @(negedge clk);

      // Vector store, 6 bytes
      issue(1'b1, 1'b1, 3'b000, 32'h300, 32'd0, 32'd6,
            128'hAABB_CCDD_EEFF_0011_1122_3344_5566_7788, 4'd6, 5'd9);
      check("vst_we", 128'(mc_we), 128'd1);
      check("vst_len", 128'(mc_len), 128'd6);
      check("vst_src", mc_src, 128'h3344_5566_7788);
      complete(0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
      check("vst_wb_valid", 128'(wb_valid), 128'd1);
      check("vst_rd", 128'(wb_rd), 128'd0);
      check("vst_value", wb_value, 128'd0);
      check("vst_pos", 128'(wb_pos), 128'd6);
      @(negedge clk);

      // Zero-length vector load skips memory entirely
      issue(1'b0, 1'b1, 3'b000, 32'h400, 32'd0, 32'd0, '0, 4'd8, 5'd3);
      check("vz_mc_valid", 128'(mc_valid), 128'd0);
      check("vz_wb_valid", 128'(wb_valid), 128'd1);
      check("vz_value", wb_value, 128'd0);
      check("vz_rd", 128'(wb_rd), 128'd3);
      @(negedge clk);

      // Oversized vector load clamps to 16 bytes
      issue(1'b0, 1'b1, 3'b000, 32'h500, 32'd0, 32'd100, '0, 4'd9, 5'd4);
      check("vbig_len", 128'(mc_len), 128'd16);
      complete(2, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
      check("vbig_value", wb_value, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
      @(negedge clk);

      // Short vector load masks bytes at index >= len
      issue(1'b0, 1'b1, 3'b000, 32'h600, 32'd0, 32'd3, '0, 4'd10, 5'd5);
      complete(0, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
      check("v3_value", wb_value, 128'h0E_0F10);
      @(negedge clk);

      // Back-to-back with sb_valid held high
      set_op(1'b0, 1'b0, 3'b010, 32'h40, 32'd0, 32'd0, '0, 4'd1, 5'd2);
      sb_valid = 1'b1;
      @(negedge clk);
      set_op(1'b0, 1'b0, 3'b010, 32'h80, 32'd0, 32'd0, '0, 4'd2, 5'd4);
      check("hs_a_addr", 128'(mc_addr), 128'h40);
      check("hs_a_len", 128'(mc_len), 128'd4);
      @(negedge clk);
      check("hs_a_stable", 128'(mc_addr), 128'h40);
      complete(0, 128'h1122_3344);
      check("hs_a_pos", 128'(wb_pos), 128'd1);
      check("hs_a_value", wb_value, 128'h1122_3344);
      check("hs_a_vacant", 128'(sb_vacant), 128'd0);
      @(negedge clk);
      check("hs_gap_mc_valid", 128'(mc_valid), 128'd0);
      check("hs_gap_vacant", 128'(sb_vacant), 128'd1);
      @(negedge clk);
      sb_valid = 1'b0;
      check("hs_b_mc_valid", 128'(mc_valid), 128'd1);
      check("hs_b_addr", 128'(mc_addr), 128'h80);
      complete(1, 128'h5566_7788);
      check("hs_b_pos", 128'(wb_pos), 128'd2);
      check("hs_b_rd", 128'(wb_rd), 128'd4);
      @(negedge clk);

      // Spurious mc_done while idle
      mc_done = 1'b1;
      @(negedge clk);
      mc_done = 1'b0;
      check("spur_wb_valid", 128'(wb_valid), 128'd0);
      check("spur_mc_valid", 128'(mc_valid), 128'd0);
      check("spur_vacant", 128'(sb_vacant), 128'd1);

      // Asynchronous reset in the middle of a request
      issue(1'b0, 1'b0, 3'b010, 32'h700, 32'd0, 32'd0, '0, 4'd11, 5'd6);
      check("ar_pre_mc_valid", 128'(mc_valid), 128'd1);
      #2 rst = 1'b0;
      #1;
      check("ar_mc_valid", 128'(mc_valid), 128'd0);
      check("ar_wb_valid", 128'(wb_valid), 128'd0);
      check("ar_vacant", 128'(sb_vacant), 128'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      mc_done = 1'b1;
      seen_wb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mc_done = 1'b0;
         if (wb_valid || mc_valid) seen_wb = 1'b1;
      end
      check("ar_no_wb_after", 128'(seen_wb), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
